// File: rtl/pmem_burst_adaptor.sv
// Physical-memory responder for the L1 cache: turns one 256-bit line request
// into a 4-beat 64-bit burst and answers the cache with a one-cycle resp_o.
module pmem_burst_adaptor #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_beat   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  output logic              resp_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [s_beat-1:0] burst_o,
  input  logic [s_beat-1:0] burst_i,
  input  logic              resp_i
);

  localparam int num_beats = s_line / s_beat;
  localparam int cnt_w     = $clog2(num_beats);
  localparam logic [31:0]      line_mask = ~((32'd1 << s_offset) - 32'd1);
  localparam logic [cnt_w-1:0] last_idx  = cnt_w'(num_beats - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [cnt_w-1:0]  beat_cnt;
  logic [s_line-1:0] wr_buf;
  logic              last_beat;

  assign last_beat = resp_i && (beat_cnt == last_idx);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (write_i)     state_next = WR_BURST;
        else if (read_i) state_next = RD_BURST;
      end
      RD_BURST: if (last_beat) state_next = DONE;
      WR_BURST: if (last_beat) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Memory-side controls decode straight from state, so nothing from the
  // cache inputs reaches the bus without first passing through a flop.
  assign read_o  = (state == RD_BURST);
  assign write_o = (state == WR_BURST);
  assign resp_o  = (state == DONE);
  assign burst_o = (state == WR_BURST) ? wr_buf[beat_cnt*s_beat +: s_beat] : '0;

  // NOTE: the wide line and write-buffer registers are reset as well, since
  // line_o must read zero after reset, including one that aborts a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      address_o <= '0;
      line_o    <= '0;
      wr_buf    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            wr_buf    <= line_i;
            address_o <= address_i & line_mask;
          end else if (read_i) begin
            address_o <= address_i & line_mask;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            line_o[beat_cnt*s_beat +: s_beat] <= burst_i;
            beat_cnt <= last_beat ? '0 : beat_cnt + cnt_w'(1);
          end
        end
        WR_BURST: begin
          if (resp_i) beat_cnt <= last_beat ? '0 : beat_cnt + cnt_w'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Self-checking bench for pmem_burst_adaptor: directed fills/writebacks from
// the test plan plus randomized traffic against a transaction-level model.
module tb_pmem_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int tests_run    = 0;
  int tests_failed = 0;
  int resp_count   = 0;

  // Model state: the line the cache last received from a completed fill.
  logic [255:0] exp_line_o;

  pmem_burst_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (resp_o === 1'b1) resp_count++;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Fill of one line; data holds beat k at bits [64k+63:64k]. pat gives the
  // resp_i sequence for the first pat_len burst cycles, random afterwards.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] data,
                         input logic [15:0] pat, input int pat_len, input string tag);
    int b   = 0;
    int cyc = 0;
    logic r;
    logic [31:0] exp_addr = {addr[31:5], 5'b0};
    read_i    = 1'b1;
    address_i = addr;
    step();
    address_i = $urandom;
    tests_run++;
    if (address_o !== exp_addr) begin
      tests_failed++;
      $display("FAIL %s addr: got %h expected %h", tag, address_o, exp_addr);
    end
    while (b < 4 && cyc < 64) begin
      tests_run++;
      if ({read_o, write_o, resp_o} !== 3'b100) begin
        tests_failed++;
        $display("FAIL %s rd_ctrl cyc%0d: got %b expected 100", tag, cyc, {read_o, write_o, resp_o});
      end
      r       = (cyc < pat_len) ? pat[cyc] : 1'($urandom_range(0, 1));
      resp_i  = r;
      burst_i = r ? data[64*b +: 64] : {$urandom, $urandom};
      step();
      if (r) b++;
      cyc++;
    end
    resp_i  = 1'b0;
    burst_i = {$urandom, $urandom};
    tests_run++;
    if (b != 4) begin
      tests_failed++;
      $display("FAIL %s rd_timeout: got %0d beats expected 4", tag, b);
    end
    tests_run++;
    if ({read_o, write_o, resp_o} !== 3'b001) begin
      tests_failed++;
      $display("FAIL %s rd_done: got %b expected 001", tag, {read_o, write_o, resp_o});
    end
    exp_line_o = data;
    tests_run++;
    if (line_o !== exp_line_o) begin
      tests_failed++;
      $display("FAIL %s line_o: got %h expected %h", tag, line_o, exp_line_o);
    end
    tests_run++;
    if (address_o !== exp_addr) begin
      tests_failed++;
      $display("FAIL %s addr_hold: got %h expected %h", tag, address_o, exp_addr);
    end
    read_i = 1'b0;
    step();
    tests_run++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL %s rd_idle: got %b expected 000", tag, {read_o, write_o, resp_o});
    end
  endtask

  // Writeback of one line with random beat gaps; hold_read keeps read_i high.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] data,
                          input logic hold_read, input string tag);
    int b   = 0;
    int cyc = 0;
    logic r;
    logic [31:0] exp_addr = {addr[31:5], 5'b0};
    write_i   = 1'b1;
    read_i    = hold_read;
    line_i    = data;
    address_i = addr;
    step();
    line_i    = rand_line();
    address_i = $urandom;
    tests_run++;
    if (address_o !== exp_addr) begin
      tests_failed++;
      $display("FAIL %s addr: got %h expected %h", tag, address_o, exp_addr);
    end
    while (b < 4 && cyc < 64) begin
      tests_run++;
      if ({read_o, write_o, resp_o} !== 3'b010) begin
        tests_failed++;
        $display("FAIL %s wr_ctrl cyc%0d: got %b expected 010", tag, cyc, {read_o, write_o, resp_o});
      end
      tests_run++;
      if (burst_o !== data[64*b +: 64]) begin
        tests_failed++;
        $display("FAIL %s burst_o beat%0d: got %h expected %h", tag, b, burst_o, data[64*b +: 64]);
      end
      r      = 1'($urandom_range(0, 1));
      resp_i = r;
      step();
      if (r) b++;
      cyc++;
    end
    resp_i = 1'b0;
    tests_run++;
    if (b != 4) begin
      tests_failed++;
      $display("FAIL %s wr_timeout: got %0d beats expected 4", tag, b);
    end
    tests_run++;
    if ({read_o, write_o, resp_o} !== 3'b001) begin
      tests_failed++;
      $display("FAIL %s wr_done: got %b expected 001", tag, {read_o, write_o, resp_o});
    end
    tests_run++;
    if (line_o !== exp_line_o) begin
      tests_failed++;
      $display("FAIL %s line_o_kept: got %h expected %h", tag, line_o, exp_line_o);
    end
    write_i = 1'b0;
    step();
    tests_run++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL %s wr_idle: got %b expected 000", tag, {read_o, write_o, resp_o});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'h0; line_i = '0; burst_i = '0;
    step();
    step();
    rst = 1'b0;
    exp_line_o = '0;
    tests_run++;
    if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 ||
        burst_o !== 64'h0 || line_o !== 256'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ctrl=%b addr=%h burst=%h line=%h expected all zero",
               {read_o, write_o, resp_o}, address_o, burst_o, line_o);
    end
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      step();
      tests_run++;
      if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== 256'h0) begin
        tests_failed++;
        $display("FAIL idle_resp_i%0d: got ctrl=%b line=%h expected 000 and zero line",
                 i, {read_o, write_o, resp_o}, line_o);
      end
    end
    resp_i = 1'b0;
  endtask

  task automatic test_fill();
    do_read(32'h0000_12F7,
            {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
            16'h000F, 4, "fill_nogap");
  endtask

  task automatic test_fill_gaps();
    do_read(32'h0000_12F7,
            {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
            16'b1011001, 7, "fill_gaps");
  endtask

  task automatic test_writeback();
    do_write(32'hABCD_0123, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 1'b0, "writeback");
  endtask

  task automatic test_priority();
    int start = resp_count;
    logic [255:0] fill = rand_line();
    do_write(32'h0000_4040, rand_line(), 1'b1, "prio_wr");
    do_read(32'h0000_4040, fill, 16'h0, 0, "prio_rd");
    tests_run++;
    if (resp_count - start != 2) begin
      tests_failed++;
      $display("FAIL prio_resp_count: got %0d expected 2", resp_count - start);
    end
  endtask

  task automatic test_reset_mid_fill();
    int start;
    read_i    = 1'b1;
    address_i = 32'h0000_8888;
    step();
    for (int i = 0; i < 2; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      step();
    end
    start  = resp_count;
    resp_i = 1'b0;
    rst    = 1'b1;
    step();
    rst    = 1'b0;
    read_i = 1'b0;
    exp_line_o = '0;
    tests_run++;
    if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== 256'h0) begin
      tests_failed++;
      $display("FAIL mid_reset: got ctrl=%b line=%h expected 000 and zero line",
               {read_o, write_o, resp_o}, line_o);
    end
    for (int i = 0; i < 3; i++) step();
    tests_run++;
    if (resp_count != start) begin
      tests_failed++;
      $display("FAIL mid_reset_no_resp: got %0d pulses expected 0", resp_count - start);
    end
    do_read(32'h0000_9A5C, rand_line(), 16'h0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_read($urandom, rand_line(), 16'h0, 0, "rand_rd");
      else
        do_write($urandom, rand_line(), 1'b0, "rand_wr");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_fill_gaps();
    test_writeback();
    test_priority();
    test_reset_mid_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
